frac_ratio_sequencer: RTL
=========================

# frac_ratio_sequencer

Fractional ratio sequencer that drives the programmable Vaucher-chain integer divider. Once per divider output period it produces the next division ratio as a cell-program word `div_p` and an extension select `div_e`, so that the average ratio equals `n_int + frac/65536`. Dithering uses a second-order MASH 1-1 sigma-delta modulator. It is clocked by the divider's modulus output, which closes the fractional-N loop.

## Interface
Parameters:
- `FRAC_W`, 16: fractional accumulator width.
- `N_MIN`, 16: smallest legal instantaneous ratio.
- `N_MAX`, 511: largest legal instantaneous ratio.

Ports:
- `in_clk` in 1: single clock, connected to the divider's `mout_clk`.
- `rst` in 1: reset, synchronous, active-high.
- `n_int` in 9: integer part of the requested ratio.
- `frac` in FRAC_W: fractional part, unsigned, scaled by 2^-FRAC_W.
- `cfg_load` in 1: capture `n_int`/`frac` into shadow registers.
- `cfg_clr` in 1: valid only with `cfg_load`; also zero both accumulators.
- `div_p` out 8: cell program bits for the divider.
- `div_e` out 3: extension select for the divider.
- `sat` out 1: sticky flag, set when an instantaneous ratio was clamped.

## Operation
- Shadow registers `n_sh` and `f_sh` are loaded when `cfg_load`=1. The divider never sees the live inputs.
- Stage 1: `acc1` is updated to `acc1 + f_sh + cin` mod 2^FRAC_W. Carry `c1` is the overflow.
- Stage 2: `acc2` is updated to `acc2 + acc1_next` mod 2^FRAC_W. Carry `c2` is the overflow. `c2_d` is `c2` delayed by one cycle.
- `delta = c1 + c2 - c2_d`, signed, range -1..+2.
- Ratio: `N = n_sh + delta`, computed 11-bit signed.
  - If N < N_MIN, N is forced to N_MIN.
  - If N > N_MAX, N is forced to N_MAX.
  - Either clamp sets `sat`.
- Encoding of N:
  - k = index of the leading one of N (4..8).
  - `div_e` = k-1.
  - `div_p` = N - 2^k, zero-extended to 8 bits.
  - This gives k active cells and ratio 2^k + `div_p`.
- `cfg_load` with `cfg_clr`=1: `acc1`, `acc2` and `c2_d` are zeroed in the same edge as the shadow load.
- `cfg_load` with `cfg_clr`=0: accumulators keep their state, so there is no phase hit.
- `sat` is cleared by `rst` or by `cfg_load`.

## Timing
- All outputs are registered.
- Reset values:
  - `div_p`=8'h00, `div_e`=3'd7 (N=256), `sat`=0.
  - `acc1`=`acc2`=0, `c2_d`=0.
  - `n_sh`=9'd256, `f_sh`=0.
- While `rst` is high, outputs hold their reset values. Reset asserted mid-sequence takes effect at the next edge.
- Every edge produces one new ratio, with no bubbles.
- Config latency:
  - `cfg_load` is sampled at edge t.
  - `div_p`/`div_e` reflect the new `n_sh`/`f_sh` from edge t+1.
- `rst` together with `cfg_load`: `rst` wins and the shadows take their reset values.
- Accumulators wrap modulo 2^FRAC_W. No other overflow is possible.
- Clamping and `sat` are evaluated in the same cycle as the output register load.

## Configuration
- Macro `MASH_DITHER_EN`.
- Defined:
  - Adds a 15-bit LFSR, x^15+x^14+1, seed 15'h0001, stepping every edge.
  - `cin` = LFSR bit 0. This breaks spurious limit cycles for rational `frac`.
  - The LFSR resets with `rst` and is not affected by `cfg_clr`.
- Undefined: `cin`=0 and the sequence is fully deterministic.

## Structure
- Shared package `frac_div_pkg` holds:
  - `FRAC_W`, `N_MIN`, `N_MAX`;
  - typedef `ratio_t` (9-bit unsigned);
  - typedef `delta_t` (3-bit signed);
  - LFSR seed/taps constants.
- Sub-module `mash_stage`: one accumulator with carry out, instantiated twice.
- Encoding, clamping and the LFSR stay in the top module.

## Test plan
- Constant ratio: `n_int`=100, `frac`=0, `cfg_clr`=1 -> every cycle `div_e`=5, `div_p`=36; `sat`=0.
- Half fraction: `n_int`=100, `frac`=16'h8000, no dither -> sum of N over 256 cycles after load is in 25727..25729; each N is in 99..102.
- Saturation: `n_int`=16, `frac`=16'hFFFF -> no N below 16 (`div_e`=3, `div_p`=0 when clamped); `sat` rises and stays set until the next `cfg_load`.
- Reconfigure without clear:
  - Steady run, then `cfg_load` with `n_int` 100->200, `cfg_clr`=0.
  - Outputs switch to 200+delta (`div_e`=6, `div_p`=72±2) at edge t+1.
  - Accumulator values are continuous across the switch.
- Reset mid-run: `rst` high for 1 cycle during the fractional sequence -> next output `div_p`=0, `div_e`=7, `sat`=0; sequence restarts from zero accumulators.
- With `MASH_DITHER_EN`: `frac`=0, `n_int`=100 -> N is no longer constant (takes values 99..102); mean over 2^15 cycles is within 100±0.01.

Source files
------------

// File: rtl/frac_div_pkg.sv
// rtl/frac_div_pkg.sv - shared constants and types for the fractional ratio sequencer
package frac_div_pkg;

  localparam int FRAC_W = 16;
  localparam int N_MIN  = 16;
  localparam int N_MAX  = 511;

  typedef logic [8:0]        ratio_t;
  typedef logic signed [2:0] delta_t;

  // x^15 + x^14 + 1 taps: register bits 14 and 13
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

endpackage

// File: rtl/mash_stage.sv
// rtl/mash_stage.sv - one MASH accumulator stage with carry out
module mash_stage
  import frac_div_pkg::*;
#(
  parameter int W = FRAC_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_addend,
  input  logic         i_cin,
  output logic [W-1:0] o_acc_next,
  output logic         o_carry
);

  logic [W-1:0] r_acc;
  logic [W:0]   w_sum;

  assign w_sum      = {1'b0, r_acc} + {1'b0, i_addend} + {{W{1'b0}}, i_cin};
  assign o_acc_next = w_sum[W-1:0];
  assign o_carry    = w_sum[W];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_acc <= '0;
    else                r_acc <= o_acc_next;
  end

endmodule

// File: rtl/frac_ratio_sequencer.sv
// rtl/frac_ratio_sequencer.sv - MASH 1-1 fractional ratio sequencer; MASH_DITHER_EN adds LFSR dither
module frac_ratio_sequencer
  import frac_div_pkg::*;
#(
  parameter int FRAC_W = frac_div_pkg::FRAC_W,
  parameter int N_MIN  = frac_div_pkg::N_MIN,
  parameter int N_MAX  = frac_div_pkg::N_MAX
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic [8:0]        n_int,
  input  logic [FRAC_W-1:0] frac,
  input  logic              cfg_load,
  input  logic              cfg_clr,
  output logic [7:0]        div_p,
  output logic [2:0]        div_e,
  output logic              sat
);

  localparam logic signed [10:0] LP_N_MIN = 11'(N_MIN);
  localparam logic signed [10:0] LP_N_MAX = 11'(N_MAX);

  ratio_t            r_n_sh;
  logic [FRAC_W-1:0] r_f_sh;
  logic              r_c2_d;
  logic [7:0]        r_div_p;
  logic [2:0]        r_div_e;
  logic              r_sat;

  logic              w_clr;
  logic              w_cin;
  logic [FRAC_W-1:0] w_acc1_next;
  logic [FRAC_W-1:0] w_acc2_unused;
  logic              w_c1;
  logic              w_c2;
  delta_t            w_delta;
  logic signed [10:0] w_delta_x;
  logic signed [10:0] w_n;
  logic              w_lo;
  logic              w_hi;
  ratio_t            w_nc;
  logic [7:0]        w_div_p;
  logic [2:0]        w_div_e;

  assign w_clr = cfg_load & cfg_clr;

`ifdef MASH_DITHER_EN
  logic [14:0] r_lfsr;

  always_ff @(posedge in_clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[13:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_cin = r_lfsr[0];
`else
  assign w_cin = 1'b0;
`endif

  mash_stage #(.W(FRAC_W)) u_stage1 (
    .i_clk      (in_clk),
    .i_rst      (rst),
    .i_clr      (w_clr),
    .i_addend   (r_f_sh),
    .i_cin      (w_cin),
    .o_acc_next (w_acc1_next),
    .o_carry    (w_c1)
  );

  mash_stage #(.W(FRAC_W)) u_stage2 (
    .i_clk      (in_clk),
    .i_rst      (rst),
    .i_clr      (w_clr),
    .i_addend   (w_acc1_next),
    .i_cin      (1'b0),
    .o_acc_next (w_acc2_unused),
    .o_carry    (w_c2)
  );

  assign w_delta   = $signed({2'b00, w_c1}) + $signed({2'b00, w_c2}) - $signed({2'b00, r_c2_d});
  assign w_delta_x = {{8{w_delta[2]}}, w_delta};
  assign w_n       = $signed({2'b00, r_n_sh}) + w_delta_x;
  assign w_lo      = w_n < LP_N_MIN;
  assign w_hi      = w_n > LP_N_MAX;
  assign w_nc      = w_lo ? ratio_t'(N_MIN) : (w_hi ? ratio_t'(N_MAX) : w_n[8:0]);

  // Leading one k selects k active cells; div_p is the remainder above 2^k
  always_comb begin
    w_div_e = 3'd3;
    w_div_p = {4'b0, w_nc[3:0]};
    if (w_nc[8]) begin
      w_div_e = 3'd7;
      w_div_p = w_nc[7:0];
    end else if (w_nc[7]) begin
      w_div_e = 3'd6;
      w_div_p = {1'b0, w_nc[6:0]};
    end else if (w_nc[6]) begin
      w_div_e = 3'd5;
      w_div_p = {2'b0, w_nc[5:0]};
    end else if (w_nc[5]) begin
      w_div_e = 3'd4;
      w_div_p = {3'b0, w_nc[4:0]};
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      r_n_sh  <= 9'd256;
      r_f_sh  <= '0;
      r_c2_d  <= 1'b0;
      r_div_p <= 8'h00;
      r_div_e <= 3'd7;
      r_sat   <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_n_sh <= n_int;
        r_f_sh <= frac;
      end
      r_c2_d  <= w_clr ? 1'b0 : w_c2;
      r_div_p <= w_div_p;
      r_div_e <= w_div_e;
      r_sat   <= cfg_load ? 1'b0 : (r_sat | w_lo | w_hi);
    end
  end

  assign div_p = r_div_p;
  assign div_e = r_div_e;
  assign sat   = r_sat;

endmodule
